// File: rtl/a0_uart_pkg.sv
// Shared types and line levels for the a0 debug UART transmitter.
package a0_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with combinational head read; a push into a full
// FIFO only succeeds when a pop frees the head slot on the same edge.
module byte_fifo
  import a0_uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/a0_uart_tx.sv
// Queues changes of the core's a0 debug byte and sends them as UART frames.
// Define A0_UART_PARITY_EN for 8E1 frames; the default build sends 8N1.
module a0_uart_tx
  import a0_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 16,
  parameter int FIFO_DEPTH        = 8,
  parameter int CAPTURE_ON_CHANGE = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [7:0]                  data_i,
  input  logic                        en_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0] prev_q, prev_d;
  logic       overflow_q, overflow_d;
  logic       push_req, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tx_state_t  state_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic       tx_q;
  logic [7:0] shift_q, shift_d;
  logic       bit_end;
`ifdef A0_UART_PARITY_EN
  logic       parity_q, parity_d;
`endif

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    push_req   = en_i && ((data_i != prev_q) || (CAPTURE_ON_CHANGE == 0));
    fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    bit_end    = (baud_q == BAUD_LAST);
    prev_d     = data_i;
    // A drop happens only when no pop frees a slot on the same edge.
    overflow_d = overflow_q || (push_req && fifo_full && !fifo_pop);
    shift_d    = shift_q;
    if (fifo_pop)
      shift_d = fifo_dout;
    else if (state_q == ST_DATA && bit_end)
      shift_d = {1'b0, shift_q[7:1]};
`ifdef A0_UART_PARITY_EN
    parity_d = fifo_pop ? ^fifo_dout : parity_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
`ifdef A0_UART_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  // tx_q is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= LINE_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            state_q <= ST_START;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= START_BIT;
          end else begin
            tx_q <= LINE_IDLE;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef A0_UART_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= ST_STOP;
              tx_q    <= LINE_IDLE;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef A0_UART_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= ST_STOP;
            tx_q    <= LINE_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= ST_IDLE;
            tx_q    <= LINE_IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          tx_q    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Bench for a0_uart_tx: directed vector table plus randomized traffic checked
// every cycle against a queue-and-frame-position model and a line decoder.
module tb_a0_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef A0_UART_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  localparam int FRAME = SLOTS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic       tx, busy, ovf;
  logic [2:0] cnt;

  a0_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CAPTURE_ON_CHANGE(1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data),
    .en_i         (en),
    .tx_o         (tx),
    .busy_o       (busy),
    .overflow_o   (ovf),
    .fifo_count_o (cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending bytes, and the position inside the current frame.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_prev = 8'h00;
  bit         m_ovf = 1'b0;

  // Independent line decoder.
  logic [7:0] rx_q[$];
  logic       rx_par_q[$];
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par = 1'b0;
  logic       rx_last = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       en;
    int         hold;
    int         frames;
    logic [7:0] byte_v;
    logic       par;
  } vec_t;

  vec_t vecs[8];
  logic sb_slots[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_line();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
`ifdef A0_UART_PARITY_EN
    if (slot == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit pop, push;
    int sz;
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_prev   = 8'h00;
      m_ovf    = 1'b0;
      return;
    end
    sz   = m_q.size();
    pop  = !m_active && (sz > 0);
    push = en && (data != m_prev);
    if (pop) m_cur = m_q.pop_front();
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back(data);
      else m_ovf = 1'b1;
    end
    if (pop) begin
      m_active = 1'b1;
      m_pos    = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) m_active = 1'b0;
    end
    m_prev = data;
  endtask

  task automatic decode();
    int slot;
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (rx_last && !tx) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_byte   = 8'h00;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        slot = rx_cnt / CPB;
        if (slot >= 1 && slot <= 8) begin
          rx_byte[slot-1] = tx;
        end else if (slot == SLOTS - 1) begin
          chk("rx_stop_bit", tx, 1);
          rx_q.push_back(rx_byte);
          rx_par_q.push_back(rx_par);
          rx_active = 1'b0;
        end else begin
          rx_par = tx;
        end
      end
    end
    rx_last = tx;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    decode();
    chk("model_tx", tx, exp_line());
    chk("model_busy", busy, (m_active || m_q.size() > 0));
    chk("model_overflow", ovf, m_ovf);
    chk("model_count", cnt, m_q.size());
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 60,  1, 8'hA5, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 200, 0, 8'h00, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 60,  0, 8'h00, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 60,  0, 8'h00, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 60,  1, 8'h07, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 60,  1, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 60,  1, 8'h00, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 60,  1, 8'h80, 1'b1};

    // 0xA5 on the line: start, 1,0,1,0,0,1,0,1, [parity 0], stop.
    sb_slots[0] = 1'b0; sb_slots[1] = 1'b1; sb_slots[2] = 1'b0; sb_slots[3] = 1'b1;
    sb_slots[4] = 1'b0; sb_slots[5] = 1'b0; sb_slots[6] = 1'b1; sb_slots[7] = 1'b0;
    sb_slots[8] = 1'b1;
`ifdef A0_UART_PARITY_EN
    sb_slots[9] = 1'b0; sb_slots[10] = 1'b1;
`else
    sb_slots[9] = 1'b1; sb_slots[10] = 1'b1;
`endif

    rst  = 1'b1;
    en   = 1'b0;
    data = 8'h00;
    tick();
    tick();
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", ovf, 0);
    chk("reset_count", cnt, 0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (5) tick();
    chk("zero_after_reset_not_queued", busy, 0);

    for (int i = 0; i < 8; i++) begin
      data = vecs[i].data;
      en   = vecs[i].en;
      rx_q.delete();
      rx_par_q.delete();
      repeat (vecs[i].hold) tick();
      chk($sformatf("vec%0d_frames", i), rx_q.size(), vecs[i].frames);
      if (vecs[i].frames > 0 && rx_q.size() > 0) begin
        chk($sformatf("vec%0d_byte", i), rx_q[0], vecs[i].byte_v);
`ifdef A0_UART_PARITY_EN
        chk($sformatf("vec%0d_parity", i), rx_par_q[0], vecs[i].par);
`endif
      end
    end

    // Single-byte frame, cycle by cycle.
    data = 8'hA5;
    tick();
    chk("sb_push_count", cnt, 1);
    chk("sb_line_before_pop", tx, 1);
    tick();
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("sb_line_c%0d", i), tx, sb_slots[i / CPB]);
      chk("sb_busy_in_frame", busy, 1);
      tick();
    end
    chk("sb_busy_after_frame", busy, 0);
    chk("sb_line_after_frame", tx, 1);

    // Overflow: six bytes on consecutive edges, the last is dropped.
    rx_q.delete();
    for (int k = 0; k < 6; k++) begin
      data = 8'(8'h11 + k);
      tick();
    end
    chk("ovf_flag", ovf, 1);
    chk("ovf_count_full", cnt, 4);
    repeat (260) tick();
    chk("ovf_frames", rx_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < rx_q.size()) chk($sformatf("ovf_byte%0d", k), rx_q[k], 8'(8'h11 + k));
    end
    chk("ovf_sticky", ovf, 1);

    // Reset during data bit 3 with a second byte still queued.
    rst = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
    data = 8'hC3;
    tick();
    data = 8'h3C;
    tick();
    repeat (17) tick();
    chk("mid_bit3_level", tx, 0);
    chk("mid_queued", cnt, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", ovf, 0);
    rst  = 1'b0;
    data = 8'h5A;
    rx_q.delete();
    repeat (60) tick();
    chk("mid_after_frames", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("mid_after_byte", rx_q[0], 8'h5A);

    // Randomized traffic at three change rates.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 99) < (p == 0 ? 2 : (p == 1 ? 6 : 25))) data = 8'($urandom);
        en  = ($urandom_range(0, 9) != 0);
        rst = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (300) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a0_uart_tx.md
# a0_uart_tx

Serialises the 8-bit debug output of the `riscv` core (`data_out_o`, low byte of `a0`) onto an 8N1 UART line so test programs can be observed on a real board. It sits directly downstream of the core. It samples the byte every clock and queues each new value in a small FIFO. A baud-rate state machine then transmits the queued bytes LSB-first.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16 — clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8 — queue entries; must be a power of two, ≥ 2.
- `CAPTURE_ON_CHANGE`, 1 — 1: enqueue only when the byte changes; 0: enqueue every enabled cycle.

Ports:
- `clk_i`  input  1  — single clock; all state updates on its rising edge.
- `rst_i`  input  1  — synchronous, active-high reset.
- `data_i`  input  8  — connect to `riscv.data_out_o`.
- `en_i`  input  1  — capture enable; when low, nothing is enqueued.
- `tx_o`  output  1  — UART line, registered, idle high.
- `busy_o`  output  1  — high when the FSM is not in IDLE or the FIFO is non-empty.
- `overflow_o`  output  1  — sticky flag, set when a byte is dropped because the FIFO is full.
- `fifo_count_o`  output  $clog2(FIFO_DEPTH)+1  — current FIFO occupancy.

## Operation
- **Capture:**
  - `prev_q` is loaded with `data_i` on every edge; it resets to 0x00.
  - A push happens when `en_i && (data_i != prev_q || !CAPTURE_ON_CHANGE)`.
  - A push while the FIFO is full and no pop occurs that edge is dropped and sets `overflow_o`.
  - A push and a pop on the same edge when the FIFO is full both succeed; the count is unchanged.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START when the FIFO is non-empty: pop into an 8-bit shift register; clear the bit counter and baud counter.
  - START drives 0 for `CLKS_PER_BIT` cycles, then → DATA.
  - DATA drives `shift[0]` and shifts right every `CLKS_PER_BIT` cycles; → next state after 8 bits.
  - STOP drives 1 for `CLKS_PER_BIT` cycles, then → IDLE.
- **Counters:**
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; a state's bit ends when the count reaches CLKS_PER_BIT-1.
  - Bit counter is 3 bits, 0..7.
- **Reset values:** `tx_o`=1, `busy_o`=0, `overflow_o`=0, `fifo_count_o`=0, state IDLE, FIFO pointers 0, `prev_q`=0x00.
- **Reset mid-frame:** the frame is aborted, `tx_o` is high after the reset edge, and queued bytes are discarded.
- A value of 0x00 immediately after reset is never enqueued, because it equals `prev_q`.

## Timing
- Push occurs on edge k, when the change is sampled; `fifo_count_o` reflects it after edge k.
- With the FSM in IDLE, the pop happens on edge k+1 and `tx_o` falls after edge k+1.
- Frame length is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- Back-to-back frames: STOP → IDLE, then one IDLE cycle (line high) with the pop, then START. The inter-frame gap is exactly 1 cycle of extra stop level.
- `overflow_o` rises after the edge on which the drop occurs and stays high until reset.

## Configuration
- Macro: `A0_UART_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits, latched at pop) for `CLKS_PER_BIT` cycles, giving 8E1 frames.
- Undefined: the state, its logic and the parity register are absent; frames are 8N1.

## Structure
- Package `a0_uart_pkg` holds:
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP), which is always declared;
  - the constants for the idle line level (1) and the start bit level (0).
- Sub-module `byte_fifo`: synchronous single-clock FIFO with parameter `DEPTH` and ports `push`/`pop`/`din`/`dout`/`full`/`empty`/`count`.
  - Read data (`dout`) is combinational at the head.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- `a0_uart_tx` contains the capture logic, the FSM, the counters and the output register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Reset:** assert `rst_i` for 2 cycles → `tx_o`=1, `busy_o`=0, `overflow_o`=0, `fifo_count_o`=0.
- **Single byte:** `data_i` 0x00→0xA5 with `en_i`=1 → `tx_o` is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. The frame is 40 cycles and `busy_o` falls after it.
- **Hold and enable:**
  - 0xA5 held for 200 cycles → exactly one frame.
  - `en_i`=0 while `data_i` changes to 0x3C → no frame.
- **Overflow:** six distinct bytes 0x11..0x16 on 6 consecutive edges → 0x11..0x15 are transmitted in order, 0x16 is dropped, and `overflow_o`=1.
- **Reset mid-frame:** `rst_i` pulsed during data bit 3 → `tx_o`=1 and `fifo_count_o`=0 after the edge. A subsequent 0x5A transmits a correct frame.
- **Parity** (`A0_UART_PARITY_EN` defined):
  - 0xA5 → parity bit 0, frame 44 cycles.
  - 0x07 → parity bit 1.
